// File: rtl/result_uart_tx.sv
// result_uart_tx: sends every change of the result bus as an 8N1 UART frame, LSB first
module result_uart_tx #(
   parameter int BAUD_DIV = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       overrun
);
   localparam int CW = $clog2(BAUD_DIV);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t        state, state_n;
   logic [CW-1:0] baud_cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shreg, shreg_n, last_val, pend_buf;
   logic          pending, change, load, bit_end;
   assign change  = data_in != last_val;
   assign load    = state == IDLE && pending;
   assign bit_end = baud_cnt == CW'(BAUD_DIV - 1);
   // next state, baud counter and shift register contents
   always_comb begin
      state_n = state;
      bit_n   = bit_idx;
      shreg_n = shreg;
      cnt_n   = (state == IDLE || bit_end) ? '0 : baud_cnt + CW'(1);
      case (state)
         IDLE:    if (pending) begin state_n = START; shreg_n = pend_buf; end
         START:   if (bit_end) begin state_n = DATA; bit_n = '0; end
         DATA:    if (bit_end) begin state_n = (bit_idx == 3'd7) ? STOP : DATA; bit_n = bit_idx + 3'd1; end
         STOP:    if (bit_end) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   // state register; line outputs are registered from the next state so tx has no path from data_in
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         baud_cnt <= cnt_n;
         bit_idx  <= bit_n;
         shreg    <= shreg_n;
         tx       <= (state_n == START) ? 1'b0 : (state_n == DATA) ? shreg_n[bit_n] : 1'b1;
         tx_busy  <= state_n != IDLE;
         tx_done  <= state_n == STOP && cnt_n == CW'(BAUD_DIV - 1);
      end
   end
   // change detector feeding the single-entry pending buffer; the newest value always wins
   always_ff @(posedge clk) begin
      if (reset) begin
         last_val <= '0;
         pend_buf <= '0;
         pending  <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= change && pending && !load;
         if (change) begin
            last_val <= data_in;
            pend_buf <= data_in;
            pending  <= 1'b1;
         end else if (load) begin
            pending <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: scoreboard bench decoding the UART line against queued expected bytes
module tb_result_uart_tx;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       tx, tx_busy, tx_done, overrun;
   logic [7:0] sb[$];
   logic [7:0] rx;
   int vecs = 0, fails = 0;
   int mon_cyc = -1, ncyc = 0, end_cyc = 0, last_gap = 0;
   int done_cnt = 0, ovr_cnt = 0, done0, ovr0, bad;

   result_uart_tx #(.BAUD_DIV(4)) dut (
      .clk(clk), .reset(reset), .data_in(data_in),
      .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .overrun(overrun)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (!(sb.size() == 0 && mon_cyc < 0 && !tx_busy) && n < budget) begin
         tick();
         n++;
      end
      check("drain_within_budget", 32'(n < budget), 32'd1);
      repeat (3) tick();
   endtask

   // monitor: decodes frames at bit centres and pops the scoreboard at each stop bit
   always @(negedge clk) begin
      ncyc++;
      if (overrun) ovr_cnt++;
      if (tx_done) done_cnt++;
      if (reset) mon_cyc = -1;
      else if (mon_cyc < 0) begin
         if (!tx) begin
            mon_cyc = 0;
            last_gap = ncyc - end_cyc;
         end
      end else mon_cyc++;
      if (mon_cyc >= 0) begin
         if (mon_cyc % 4 == 2) begin
            if (mon_cyc == 2) check("start_bit", 32'({tx, tx_busy}), 32'b01);
            else if (mon_cyc == 38) check("stop_bit", 32'({tx, tx_busy}), 32'b11);
            else rx[mon_cyc / 4 - 1] = tx;
         end
         if (mon_cyc == 39) begin
            check("done_on_last_stop_cycle", 32'(tx_done), 32'd1);
            check("frame_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("frame_byte", 32'(rx), 32'(sb.pop_front()));
         end
         if (mon_cyc == 40) begin
            check("idle_after_stop", 32'({tx, tx_busy, tx_done}), 32'b100);
            end_cyc = ncyc;
            mon_cyc = -1;
         end
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // directed stimulus; expected bytes are pushed as each value is applied
   initial begin
      repeat (3) tick();
      check("reset_outputs", 32'({tx, tx_busy, tx_done, overrun}), 32'b1000);
      reset = 1'b0;
      bad = 0;
      repeat (100) begin
         tick();
         if (!tx || tx_busy || tx_done) bad++;
      end
      check("idle_zero_no_activity", 32'(bad), 32'd0);
      check("idle_zero_no_done", 32'(done_cnt), 32'd0);

      // single frame 0x05 with exact timing
      done0 = done_cnt;
      data_in = 8'h05;
      sb.push_back(8'h05);
      tick();
      check("edge_n_still_idle", 32'({tx, tx_busy}), 32'b10);
      tick();
      check("edge_n1_start", 32'({tx, tx_busy}), 32'b01);
      repeat (3) tick();
      check("start_last_cycle", 32'(tx), 32'd0);
      tick();
      check("bit0_of_05", 32'(tx), 32'd1);
      repeat (35) tick();
      check("done_at_edge_n40", 32'(tx_done), 32'd1);
      tick();
      check("after_frame", 32'({tx, tx_busy, tx_done}), 32'b100);
      wait_idle(200);
      check("single_done_pulse", 32'(done_cnt - done0), 32'd1);

      // overrun: 0x01,0x02,0x03 one cycle apart, 0x02 is lost
      ovr0 = ovr_cnt;
      data_in = 8'h01;
      sb.push_back(8'h01);
      tick();
      data_in = 8'h02;
      tick();
      check("no_overrun_on_load_cycle", 32'(overrun), 32'd0);
      data_in = 8'h03;
      sb.push_back(8'h03);
      tick();
      check("overrun_pulse", 32'(overrun), 32'd1);
      wait_idle(300);
      check("overrun_count", 32'(ovr_cnt - ovr0), 32'd1);

      // change on the exact load cycle: both sent, one idle cycle apart, no overrun
      ovr0 = ovr_cnt;
      data_in = 8'h10;
      sb.push_back(8'h10);
      tick();
      data_in = 8'h20;
      sb.push_back(8'h20);
      tick();
      check("no_overrun_simultaneous", 32'(overrun), 32'd0);
      wait_idle(300);
      check("b2b_gap", 32'(last_gap), 32'd1);
      check("b2b_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);

      // processor-like counting 1..9 every 50 cycles
      ovr0 = ovr_cnt;
      done0 = done_cnt;
      for (int v = 1; v <= 9; v++) begin
         data_in = 8'(v);
         sb.push_back(8'(v));
         repeat (50) tick();
      end
      wait_idle(200);
      check("count_no_overrun", 32'(ovr_cnt - ovr0), 32'd0);
      check("count_nine_frames", 32'(done_cnt - done0), 32'd9);

      // reset during a 0xA5 frame aborts it and clears last_val
      done0 = done_cnt;
      data_in = 8'hA5;
      tick();
      repeat (15) tick();
      check("busy_before_reset", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      tick();
      check("abort_on_reset", 32'({tx, tx_busy, tx_done}), 32'b100);
      data_in = 8'h00;
      tick();
      reset = 1'b0;
      repeat (60) tick();
      check("abort_no_done", 32'(done_cnt - done0), 32'd0);
      check("abort_stays_idle", 32'({tx, tx_busy}), 32'b10);
      data_in = 8'hA5;
      sb.push_back(8'hA5);
      wait_idle(200);
      check("resend_after_reset", 32'(done_cnt - done0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
